// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer: FSM state
// encoding and the ALU function codes.
package alu_op_sequencer_pkg;

  localparam int ALUFN_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } seq_state_t;

  localparam logic [ALUFN_W-1:0] ALUFN_ADD   = 6'b000000;
  localparam logic [ALUFN_W-1:0] ALUFN_SUB   = 6'b000001;
  localparam logic [ALUFN_W-1:0] ALUFN_MUL   = 6'b000010;
  localparam logic [ALUFN_W-1:0] ALUFN_AND   = 6'b011000;
  localparam logic [ALUFN_W-1:0] ALUFN_OR    = 6'b011110;
  localparam logic [ALUFN_W-1:0] ALUFN_XOR   = 6'b010110;
  localparam logic [ALUFN_W-1:0] ALUFN_SHL   = 6'b100000;
  localparam logic [ALUFN_W-1:0] ALUFN_SHR   = 6'b100001;
  localparam logic [ALUFN_W-1:0] ALUFN_SRA   = 6'b100011;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPEQ = 6'b110011;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPLT = 6'b110101;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPLE = 6'b110111;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signal bundle of the sequencer.
// slave = sequencer side, master = command source / ALU / consumer side.
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [ALUFN_W-1:0] req_alufn;
  logic               req_chain;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [ALUFN_W-1:0] alu_alufn;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_z;
  logic               alu_n;
  logic               alu_v;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_z;
  logic               rsp_n;
  logic               rsp_v;

  modport slave (
    input  req_valid, req_a, req_b, req_alufn, req_chain,
    output req_ready,
    output alu_a, alu_b, alu_alufn,
    input  alu_out, alu_z, alu_n, alu_v,
    output rsp_valid, rsp_data, rsp_z, rsp_n, rsp_v,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_alufn, req_chain,
    input  req_ready,
    input  alu_a, alu_b, alu_alufn,
    output alu_out, alu_z, alu_n, alu_v,
    input  rsp_valid, rsp_data, rsp_z, rsp_n, rsp_v,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer_fsm.sv
// Control FSM of the sequencer (module alu_seq_fsm): IDLE -> SETTLE -> RESP,
// settle counter, and the load/capture/complete strobes for the datapath.
module alu_seq_fsm
  import alu_op_sequencer_pkg::*;
#(
  parameter int LAT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic rsp_ready,
  output logic req_ready,
  output logic load,
  output logic capture,
  output logic complete,
  output logic busy,
  output logic rsp_valid
);
  localparam int CW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LAT_CYCLES - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign load      = req_valid && req_ready;
  assign capture   = (state == ST_SETTLE) && (cnt == LAST);
  assign complete  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_SETTLE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer top: operand/alufn launch registers, result capture
// and op_count. Optional result chaining under `ALU_SEQ_CHAIN_EN.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LAT_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  logic             load;
  logic             capture;
  logic             complete;
  logic [WIDTH-1:0] a_next;

`ifdef ALU_SEQ_CHAIN_EN
  logic [WIDTH-1:0] last_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_result <= '0;
    else if (complete) last_result <= bus.rsp_data;
  end

  assign a_next = bus.req_chain ? last_result : bus.req_a;
`else
  assign a_next = bus.req_a;
`endif

  alu_seq_fsm #(
    .LAT_CYCLES(LAT_CYCLES)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .rsp_ready (bus.rsp_ready),
    .req_ready (bus.req_ready),
    .load      (load),
    .capture   (capture),
    .complete  (complete),
    .busy      (busy),
    .rsp_valid (bus.rsp_valid)
  );

  // alu_* are deliberately left holding the last operation between requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_alufn <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_z     <= 1'b0;
      bus.rsp_n     <= 1'b0;
      bus.rsp_v     <= 1'b0;
      op_count      <= '0;
    end else begin
      if (load) begin
        bus.alu_a     <= a_next;
        bus.alu_b     <= bus.req_b;
        bus.alu_alufn <= bus.req_alufn;
      end
      if (capture) begin
        bus.rsp_data <= bus.alu_out;
        bus.rsp_z    <= bus.alu_z;
        bus.rsp_n    <= bus.alu_n;
        bus.rsp_v    <= bus.alu_v;
      end
      if (complete) op_count <= op_count + 1'b1;
    end
  end
endmodule
